// File: rtl/imem_debug_port_arbiter.sv
// Round-robin arbiter sharing the instruction memory debug port between the program loader
// and the debugger. Optional access counters are enabled by defining IMEM_ARB_STATS_EN.
module imem_debug_port_arbiter #(
  parameter int unsigned MemAw  = 12,
  parameter bit          RrInit = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_req_i,
  input  logic [29:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        ld_gnt_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [29:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        addr_err_o,
`ifdef IMEM_ARB_STATS_EN
  output logic [31:0] ld_wr_cnt_o,
  output logic [31:0] dbg_acc_cnt_o,
`endif
  output logic        mem_we_o,
  output logic [29:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;   // 1: debugger was granted last
  logic        win_q, win_d;     // 1: debugger owns the current access
  logic        rd_q, rd_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sel;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    rd_d    = rd_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_req_i || dbg_req_i) begin
          sel     = (ld_req_i && dbg_req_i) ? ~last_q : dbg_req_i;
          last_d  = sel;
          win_d   = sel;
          addr_d  = sel ? dbg_addr_i : ld_addr_i;
          wdata_d = sel ? dbg_wdata_i : ld_wdata_i;
          rd_d    = sel & ~dbg_we_i;
          err_d   = |(addr_d >> MemAw);
          // Out-of-range writes still complete as an access but never reach the array.
          we_d    = ~rd_d & ~err_d;
          state_d = StAccess;
        end
      end
      StAccess: state_d = rd_q ? StRdResp : StIdle;
      StRdResp: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= RrInit;
      win_q   <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  logic in_access;
  assign in_access    = (state_q == StAccess);
  assign ld_gnt_o     = in_access & ~win_q;
  assign dbg_gnt_o    = in_access & win_q;
  assign addr_err_o   = in_access & err_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign dbg_rvalid_o = (state_q == StRdResp);
  assign dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : '0;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] ld_wr_cnt_q, dbg_acc_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_wr_cnt_q   <= '0;
      dbg_acc_cnt_q <= '0;
    end else begin
      if (ld_gnt_o)  ld_wr_cnt_q   <= ld_wr_cnt_q + 32'd1;
      if (dbg_gnt_o) dbg_acc_cnt_q <= dbg_acc_cnt_q + 32'd1;
    end
  end

  assign ld_wr_cnt_o   = ld_wr_cnt_q;
  assign dbg_acc_cnt_o = dbg_acc_cnt_q;
`endif

endmodule
